// File: rtl/scarv_cop_common_pkg.sv
// Shared SCARV coprocessor definitions.
// Holds the one-hot subclass bit indices used to decode RNG instructions
// and the default Fibonacci feedback masks for the 32- and 64-bit LFSRs.
package scarv_cop_common;

  localparam int SCARV_COP_SCLASS_RSEED = 0;
  localparam int SCARV_COP_SCLASS_RSAMP = 1;
  localparam int SCARV_COP_SCLASS_RTEST = 2;

  localparam logic [31:0] SCARV_COP_RNG_TAPS_32 = 32'h80200003;
  localparam logic [63:0] SCARV_COP_RNG_TAPS_64 = 64'hD800000000000000;

  // Default tap mask for a given LFSR width, zero-extended to 64 bits.
  function automatic logic [63:0] scarv_cop_rng_default_taps(input int width);
    return (width == 64) ? SCARV_COP_RNG_TAPS_64 : {32'h0, SCARV_COP_RNG_TAPS_32};
  endfunction

endpackage

// File: rtl/scarv_cop_rng_fifo.sv
// Sample pool FIFO for the RNG.
// Ports:
//   g_clk, g_reset  clock, asynchronous active-high reset
//   push, wdata     write a word (accepted when not full, or when popping)
//   pop, rdata      read/remove the head word (rdata is the current head)
//   flush           empty the FIFO; overrides push and pop
//   count, full, empty  occupancy status
module scarv_cop_rng_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     g_clk,
  input  logic                     g_reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rptr];

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge g_clk) begin
    if (do_push && !flush) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/scarv_cop_rng_pool.sv
// LFSR-based random number pool for the SCARV coprocessor.
// An LFSR free-runs and every STRIDE cycles offers its next low word to a
// sample FIFO. rseed reseeds and flushes, rsamp pops a sample (stalling
// while the pool is empty), rtest reports pool/health status. A repetition
// health test latches a sticky fail flag, after which rsamp returns zero.
// Ports:
//   g_clk, g_reset        clock, asynchronous active-high reset
//   rng_ivalid, id_subclass, rng_rs1   instruction request
//   rng_idone, rng_cpr_rd_ben, rng_cpr_rd_wdata   completion/writeback
//   cop_random, cop_rand_sample         sample observation hint
module scarv_cop_rng_pool import scarv_cop_common::*; #(
  parameter int                    LFSR_WIDTH      = 32,
  parameter logic [LFSR_WIDTH-1:0] LFSR_TAPS       = LFSR_WIDTH'(scarv_cop_rng_default_taps(LFSR_WIDTH)),
  parameter logic [LFSR_WIDTH-1:0] RNG_RESET_VALUE = LFSR_WIDTH'(1),
  parameter int                    POOL_DEPTH      = 4,
  parameter int                    STRIDE          = 1,
  parameter int                    REP_LIMIT       = 4
) (
  input  logic        g_clk,
  input  logic        g_reset,
  input  logic        rng_ivalid,
  output logic        rng_idone,
  input  logic [15:0] id_subclass,
  input  logic [31:0] rng_rs1,
  output logic [3:0]  rng_cpr_rd_ben,
  output logic [31:0] rng_cpr_rd_wdata,
  output logic [31:0] cop_random,
  output logic        cop_rand_sample
);

  localparam int CW = $clog2(POOL_DEPTH) + 1;
  localparam int SW = (STRIDE > 1) ? $clog2(STRIDE) : 1;
  localparam int RW = $clog2(REP_LIMIT);

  logic [LFSR_WIDTH-1:0] lfsr;
  logic [LFSR_WIDTH-1:0] lfsr_next;
  logic [SW-1:0]         stride_cnt;
  logic                  stride_wrap;
  logic [RW-1:0]         rep_cnt;
  logic [31:0]           prev_word;
  logic                  prev_vld;
  logic                  fail;
  logic                  rep_hit;
  logic                  fail_set;

  logic                  is_seed, is_samp, is_test, samp_done;
  logic                  push_ok, fifo_pop, fifo_flush;
  logic                  full, empty;
  logic [31:0]           head;
  logic [CW-1:0]         count;
  logic [31:0]           test_word;
  logic                  unused_subclass;

  assign unused_subclass = ^id_subclass;

  // Priority decode: rseed > rsamp > rtest.
  assign is_seed = rng_ivalid && id_subclass[SCARV_COP_SCLASS_RSEED];
  assign is_samp = rng_ivalid && !id_subclass[SCARV_COP_SCLASS_RSEED]
                   && id_subclass[SCARV_COP_SCLASS_RSAMP];
  assign is_test = rng_ivalid && !id_subclass[SCARV_COP_SCLASS_RSEED]
                   && !id_subclass[SCARV_COP_SCLASS_RSAMP]
                   && id_subclass[SCARV_COP_SCLASS_RTEST];

  assign samp_done = is_samp && (fail || !empty);

  assign lfsr_next   = {lfsr[LFSR_WIDTH-2:0], ^(lfsr & LFSR_TAPS)};
  assign stride_wrap = (stride_cnt == SW'(STRIDE - 1));

  // Offered word is the freshly stepped state, so the first sample after a
  // (re)seed is one LFSR step past the seed.
  assign fifo_pop   = is_samp && !fail && !empty;
  assign push_ok    = stride_wrap && !fail && !is_seed && (!full || fifo_pop);
  assign rep_hit    = prev_vld && (lfsr_next[31:0] == prev_word);
  assign fail_set   = push_ok && rep_hit && (rep_cnt == RW'(REP_LIMIT - 2));
  assign fifo_flush = is_seed || fail_set;

  assign test_word = {16'h0, 8'(count), 5'b0, full, !empty, !fail};

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      lfsr       <= RNG_RESET_VALUE;
      stride_cnt <= '0;
      rep_cnt    <= '0;
      prev_word  <= '0;
      prev_vld   <= 1'b0;
      fail       <= 1'b0;
    end else if (is_seed) begin
      lfsr       <= (rng_rs1 == 32'h0) ? RNG_RESET_VALUE : {(LFSR_WIDTH/32){rng_rs1}};
      stride_cnt <= '0;
      rep_cnt    <= '0;
      prev_vld   <= 1'b0;
      fail       <= 1'b0;
    end else begin
      lfsr       <= lfsr_next;
      stride_cnt <= stride_wrap ? '0 : stride_cnt + SW'(1);
      if (push_ok) begin
        prev_word <= lfsr_next[31:0];
        prev_vld  <= 1'b1;
        rep_cnt   <= rep_hit ? rep_cnt + RW'(1) : '0;
      end
      if (fail_set) fail <= 1'b1;
    end
  end

  scarv_cop_rng_fifo #(
    .DEPTH (POOL_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .g_clk   (g_clk),
    .g_reset (g_reset),
    .push    (push_ok),
    .pop     (fifo_pop),
    .flush   (fifo_flush),
    .wdata   (lfsr_next[31:0]),
    .rdata   (head),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  always_comb begin
    rng_idone        = 1'b0;
    rng_cpr_rd_ben   = 4'h0;
    rng_cpr_rd_wdata = 32'h0;
    cop_random       = 32'h0;
    cop_rand_sample  = 1'b0;
    if (is_seed) begin
      rng_idone = 1'b1;
    end else if (samp_done) begin
      rng_idone        = 1'b1;
      rng_cpr_rd_ben   = 4'hF;
      rng_cpr_rd_wdata = fail ? 32'h0 : head;
      cop_random       = fail ? 32'h0 : head;
      cop_rand_sample  = 1'b1;
    end else if (is_test) begin
      rng_idone        = 1'b1;
      rng_cpr_rd_ben   = 4'hF;
      rng_cpr_rd_wdata = test_word;
    end
  end

endmodule

// File: tb/tb_scarv_cop_rng_pool.sv
// Directed bench for scarv_cop_rng_pool: default 32-bit pool (unit 0),
// a stuck-LFSR pool for the health test (unit 1) and a 64-bit pool (unit 2).
module tb_scarv_cop_rng_pool;
  import scarv_cop_common::*;

  localparam logic [15:0] SC_SEED = 16'(1 << SCARV_COP_SCLASS_RSEED);
  localparam logic [15:0] SC_SAMP = 16'(1 << SCARV_COP_SCLASS_RSAMP);
  localparam logic [15:0] SC_TEST = 16'(1 << SCARV_COP_SCLASS_RTEST);

  logic        g_clk;
  logic        g_reset;
  logic        ivalid  [3];
  logic [15:0] sub     [3];
  logic [31:0] rs1     [3];
  logic        idone   [3];
  logic [3:0]  ben_o   [3];
  logic [31:0] wdata   [3];
  logic [31:0] rnd     [3];
  logic        smp     [3];

  int n_cmp = 0;
  int n_bad = 0;

  scarv_cop_rng_pool dut (
    .g_clk (g_clk), .g_reset (g_reset), .rng_ivalid (ivalid[0]), .rng_idone (idone[0]),
    .id_subclass (sub[0]), .rng_rs1 (rs1[0]), .rng_cpr_rd_ben (ben_o[0]),
    .rng_cpr_rd_wdata (wdata[0]), .cop_random (rnd[0]), .cop_rand_sample (smp[0])
  );

  scarv_cop_rng_pool #(.LFSR_TAPS (32'h80000000)) dut_h (
    .g_clk (g_clk), .g_reset (g_reset), .rng_ivalid (ivalid[1]), .rng_idone (idone[1]),
    .id_subclass (sub[1]), .rng_rs1 (rs1[1]), .rng_cpr_rd_ben (ben_o[1]),
    .rng_cpr_rd_wdata (wdata[1]), .cop_random (rnd[1]), .cop_rand_sample (smp[1])
  );

  scarv_cop_rng_pool #(.LFSR_WIDTH (64)) dut_w (
    .g_clk (g_clk), .g_reset (g_reset), .rng_ivalid (ivalid[2]), .rng_idone (idone[2]),
    .id_subclass (sub[2]), .rng_rs1 (rs1[2]), .rng_cpr_rd_ben (ben_o[2]),
    .rng_cpr_rd_wdata (wdata[2]), .cop_random (rnd[2]), .cop_rand_sample (smp[2])
  );

  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] step32(input logic [31:0] s);
    return {s[30:0], ^(s & 32'h80200003)};
  endfunction

  // Present one instruction from posedge+1, hold until done, return at the
  // following posedge+1 with the request removed.
  task automatic issue(input int u, input logic [15:0] sc, input logic [31:0] rs,
                       output int waits, output logic [31:0] data, output logic [3:0] ben,
                       output logic sflag, output logic [31:0] sword);
    waits = 0; data = '0; ben = '0; sflag = 1'b0; sword = '0;
    ivalid[u] = 1'b1; sub[u] = sc; rs1[u] = rs;
    @(negedge g_clk);
    while (!idone[u] && waits < 20) begin
      waits++;
      @(negedge g_clk);
    end
    if (!idone[u]) check("issue_timeout", {63'h0, idone[u]}, 64'h1);
    else begin
      data = wdata[u]; ben = ben_o[u]; sflag = smp[u]; sword = rnd[u];
    end
    @(posedge g_clk); #1;
    ivalid[u] = 1'b0; sub[u] = '0; rs1[u] = '0;
  endtask

  logic [31:0] steps [0:16];
  logic [31:0] exp_fill [4] = '{32'h00000003, 32'h00000006, 32'h0000000D, 32'h0000001B};
  logic [31:0] exp_w64  [3] = '{32'h4B4B4B4B, 32'h96969696, 32'h2D2D2D2C};

  initial begin
    int          w;
    logic [31:0] d;
    logic [3:0]  b;
    logic        s;
    logic [31:0] r;

    for (int i = 0; i < 3; i++) begin
      ivalid[i] = 1'b0; sub[i] = '0; rs1[i] = '0;
    end
    steps[0] = 32'h1;
    for (int k = 1; k <= 16; k++) steps[k] = step32(steps[k-1]);

    g_reset = 1'b0;
    #1 g_reset = 1'b1;
    #2;
    check("rst_idone", {63'h0, idone[0]}, 64'h0);
    check("rst_ben",   {60'h0, ben_o[0]}, 64'h0);
    check("rst_wdata", {32'h0, wdata[0]}, 64'h0);
    check("rst_smp",   {63'h0, smp[0]},   64'h0);
    check("rst_rnd",   {32'h0, rnd[0]},   64'h0);

    repeat (2) @(posedge g_clk);
    #1 g_reset = 1'b0;
    repeat (4) @(posedge g_clk);
    #1;

    // Pool full after four pushes.
    issue(0, SC_TEST, 0, w, d, b, s, r);
    check("fill_rtest", {32'h0, d}, 64'h00000407);
    check("fill_rtest_ben", {60'h0, b}, 64'hF);

    for (int k = 0; k < 4; k++) begin
      issue(0, SC_SAMP, 0, w, d, b, s, r);
      check($sformatf("drain_word%0d", k), {32'h0, d}, {32'h0, exp_fill[k]});
      check($sformatf("drain_wait%0d", k), 64'(w), 64'h0);
    end
    check("drain_ben", {60'h0, b}, 64'hF);
    check("drain_smp", {63'h0, s}, 64'h1);
    check("drain_rnd", {32'h0, r}, {32'h0, d});

    // Refilled on each pop: step 5 was dropped while full, step 6 onward kept.
    issue(0, SC_SAMP, 0, w, d, b, s, r);
    check("drain_word4", {32'h0, d}, 64'h0000006D);
    for (int n = 6; n <= 13; n++) begin
      issue(0, SC_SAMP, 0, w, d, b, s, r);
      check($sformatf("stream_word%0d", n), {32'h0, d}, {32'h0, steps[n+1]});
      check($sformatf("stream_wait%0d", n), 64'(w), 64'h0);
    end
    issue(0, SC_TEST, 0, w, d, b, s, r);
    check("stream_rtest", {32'h0, d}, 64'h00000407);

    // No subclass bit: nothing completes.
    ivalid[0] = 1'b1; sub[0] = 16'h0;
    repeat (2) begin
      @(negedge g_clk);
      check("nosub_idone", {63'h0, idone[0]}, 64'h0);
      check("nosub_wdata", {32'h0, wdata[0]}, 64'h0);
      check("nosub_ben",   {60'h0, ben_o[0]}, 64'h0);
    end
    @(posedge g_clk); #1;
    ivalid[0] = 1'b0;

    // Zero seed behaves like reset; first rsamp stalls one cycle.
    issue(0, SC_SEED, 32'h0, w, d, b, s, r);
    check("seed0_wait", 64'(w), 64'h0);
    check("seed0_ben", {60'h0, b}, 64'h0);
    check("seed0_wdata", {32'h0, d}, 64'h0);
    issue(0, SC_SAMP, 0, w, d, b, s, r);
    check("seed0_stall", 64'(w), 64'h1);
    check("seed0_word", {32'h0, d}, 64'h00000003);
    check("seed0_rnd", {32'h0, r}, 64'h00000003);

    // rseed wins over rsamp; rsamp wins over rtest.
    issue(0, SC_SEED | SC_SAMP, 32'h12345678, w, d, b, s, r);
    check("prio_seed_ben", {60'h0, b}, 64'h0);
    check("prio_seed_smp", {63'h0, s}, 64'h0);
    issue(0, SC_SAMP, 0, w, d, b, s, r);
    check("prio_word1", {32'h0, d}, 64'h2468ACF1);
    check("prio_stall", 64'(w), 64'h1);
    issue(0, SC_SAMP | SC_TEST, 0, w, d, b, s, r);
    check("prio_word2", {32'h0, d}, 64'h48D159E2);
    check("prio_samp_smp", {63'h0, s}, 64'h1);

    // Health: all-ones with a single top tap never changes.
    issue(1, SC_SEED, 32'hFFFFFFFF, w, d, b, s, r);
    repeat (3) @(posedge g_clk);
    #1;
    issue(1, SC_TEST, 0, w, d, b, s, r);
    check("health_pre", {32'h0, d}, 64'h00000303);
    issue(1, SC_TEST, 0, w, d, b, s, r);
    check("health_fail", {32'h0, d}, 64'h00000000);
    issue(1, SC_SAMP, 0, w, d, b, s, r);
    check("health_samp", {32'h0, d}, 64'h0);
    check("health_samp_ben", {60'h0, b}, 64'hF);
    check("health_samp_wait", 64'(w), 64'h0);
    check("health_samp_smp", {63'h0, s}, 64'h1);
    issue(1, SC_SEED, 32'h12345678, w, d, b, s, r);
    issue(1, SC_TEST, 0, w, d, b, s, r);
    check("health_clear", {32'h0, d}, 64'h00000001);

    // 64-bit LFSR: replicated seed, low halves sampled.
    issue(2, SC_SEED, 32'hA5A5A5A5, w, d, b, s, r);
    for (int k = 0; k < 3; k++) begin
      issue(2, SC_SAMP, 0, w, d, b, s, r);
      check($sformatf("w64_word%0d", k), {32'h0, d}, {32'h0, exp_w64[k]});
    end

    // Reset during a stalled rsamp.
    issue(0, SC_SEED, 32'h0BADF00D, w, d, b, s, r);
    ivalid[0] = 1'b1; sub[0] = SC_SAMP;
    #2 g_reset = 1'b1;
    #1;
    check("rst_stall_idone", {63'h0, idone[0]}, 64'h0);
    sub[0] = SC_TEST;
    #1;
    check("rst_mid_count", {32'h0, wdata[0]}, 64'h00000001);
    ivalid[0] = 1'b0; sub[0] = '0;
    #1;
    check("rst_mid_idone", {63'h0, idone[0]}, 64'h0);
    check("rst_mid_wdata", {32'h0, wdata[0]}, 64'h0);
    @(posedge g_clk); #1;
    g_reset = 1'b0;
    issue(0, SC_SAMP, 0, w, d, b, s, r);
    check("rst_restart_word", {32'h0, d}, 64'h00000003);
    check("rst_restart_wait", 64'(w), 64'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
